// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - WIDTH-bit universal shift register with automatic LSB-first serial transfer
module universal_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [1:0]       Mode,
  input  logic             SerInR,
  input  logic             SerInL,
  input  logic [WIDTH-1:0] D,
  input  logic             Start,
  output logic [WIDTH-1:0] Q,
  output logic             SerOut,
  output logic             Busy,
  output logic             Done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state logic: Start wins over Mode in IDLE; XFER shifts right until the counter empties
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (Start) begin
          // Accepting edge only arms the transfer; the first shift is on the next edge
          state_d = XFER;
          cnt_d   = CNT_W'(WIDTH);
          busy_d  = 1'b1;
        end else begin
          case (Mode)
            MODE_HOLD:  q_d = q_q;
            MODE_RIGHT: q_d = {SerInR, q_q[WIDTH-1:1]};
            MODE_LEFT:  q_d = {q_q[WIDTH-2:0], SerInL};
            MODE_LOAD:  q_d = D;
            default:    q_d = q_q;
          endcase
        end
      end
      XFER: begin
        q_d   = {SerInR, q_q[WIDTH-1:1]};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-high reset taking priority over everything
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Q      = q_q;
  assign SerOut = q_q[0];
  assign Busy   = busy_q;
  assign Done   = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - self-checking bench for universal_shift_reg
module tb_universal_shift_reg;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [1:0]   Mode;
  logic         SerInR;
  logic         SerInL;
  logic [W-1:0] D;
  logic         Start;
  logic [W-1:0] Q;
  logic         SerOut;
  logic         Busy;
  logic         Done;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: word, whether a transfer is running, shifts left, done pulse
  logic [W-1:0] m_q;
  logic         m_busy;
  int           m_left;
  logic         m_done;

  typedef struct {
    logic         rst;
    logic [1:0]   mode;
    logic         sir;
    logic         sil;
    logic [W-1:0] d;
    logic         start;
    logic [W-1:0] exp_q;
    logic         exp_busy;
    logic         exp_done;
  } vec_t;

  vec_t tv [12];

  universal_shift_reg #(.WIDTH(W)) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .Mode   (Mode),
    .SerInR (SerInR),
    .SerInL (SerInL),
    .D      (D),
    .Start  (Start),
    .Q      (Q),
    .SerOut (SerOut),
    .Busy   (Busy),
    .Done   (Done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (Rst) begin
      m_q = '0; m_busy = 1'b0; m_left = 0; m_done = 1'b0;
    end else if (m_busy) begin
      m_q    = (m_q >> 1) | (W'(SerInR) << (W - 1));
      m_left = m_left - 1;
      m_done = (m_left == 0);
      if (m_left == 0) m_busy = 1'b0;
    end else begin
      m_done = 1'b0;
      if (Start) begin
        m_busy = 1'b1;
        m_left = W;
      end else begin
        case (Mode)
          2'b01:   m_q = (m_q >> 1) | (W'(SerInR) << (W - 1));
          2'b10:   m_q = (m_q << 1) | W'(SerInL);
          2'b11:   m_q = D;
          default: m_q = m_q;
        endcase
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".q"},      Q,           m_q);
    check({tag, ".serout"}, W'(SerOut),  W'(m_q[0]));
    check({tag, ".busy"},   W'(Busy),    W'(m_busy));
    check({tag, ".done"},   W'(Done),    W'(m_done));
  endtask

  task automatic step(input logic rst, input logic [1:0] mode, input logic sir, input logic sil,
                      input logic [W-1:0] d, input logic start, input string tag);
    Rst = rst; Mode = mode; SerInR = sir; SerInL = sil; D = d; Start = start;
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    check_model(tag);
  endtask

  // Loads 0xA5, starts a transfer, checks SerOut before every shift, Busy length and Done pulse.
  // With noisy=1 the ignored inputs are driven to load/start values throughout the transfer.
  task automatic run_xfer(input bit noisy, input string tag);
    logic [W-1:0] bits;
    int busy_cycles;
    bits = 8'b1010_0101;
    busy_cycles = 0;
    step(0, 2'b11, 0, 0, 8'hA5, 0, {tag, ".load"});
    step(0, 2'b00, 0, 0, 8'h00, 1, {tag, ".accept"});
    check({tag, ".accept_q"}, Q, 8'hA5);
    if (Busy) busy_cycles++;
    for (int i = 0; i < W; i++) begin
      check({tag, ".serout_bit"}, W'(SerOut), W'(bits[i]));
      if (noisy) step(0, 2'b11, 0, 1, 8'hFF, 1, {tag, ".shift"});
      else       step(0, 2'b00, 0, 0, 8'h00, 0, {tag, ".shift"});
      if (Busy) busy_cycles++;
    end
    check({tag, ".busy_cycles"}, W'(busy_cycles), W'(W));
    check({tag, ".final_q"}, Q, 8'h00);
    check({tag, ".done_pulse"}, W'(Done), 8'h01);
    step(0, 2'b00, 0, 0, 8'h00, 0, {tag, ".after"});
    check({tag, ".done_cleared"}, W'(Done), 8'h00);
    check({tag, ".no_second_xfer"}, W'(Busy), 8'h00);
  endtask

  initial begin
    int done_seen;
    Rst = 1; Mode = 2'b11; SerInR = 0; SerInL = 0; D = 8'hFF; Start = 0;
    m_q = '0; m_busy = 0; m_left = 0; m_done = 0;

    //          rst mode   sir sil d      start exp_q  busy done
    tv[0]  = '{1, 2'b11, 0, 0, 8'hFF, 0, 8'h00, 0, 0};
    tv[1]  = '{1, 2'b11, 0, 0, 8'hFF, 0, 8'h00, 0, 0};
    tv[2]  = '{0, 2'b11, 0, 0, 8'hA5, 0, 8'hA5, 0, 0};
    tv[3]  = '{0, 2'b01, 1, 0, 8'h00, 0, 8'hD2, 0, 0};
    tv[4]  = '{0, 2'b00, 1, 1, 8'h3C, 0, 8'hD2, 0, 0};
    tv[5]  = '{0, 2'b00, 0, 1, 8'hFF, 0, 8'hD2, 0, 0};
    tv[6]  = '{0, 2'b00, 1, 0, 8'h11, 0, 8'hD2, 0, 0};
    tv[7]  = '{0, 2'b11, 0, 0, 8'hA5, 0, 8'hA5, 0, 0};
    tv[8]  = '{0, 2'b10, 0, 0, 8'h00, 0, 8'h4A, 0, 0};
    tv[9]  = '{0, 2'b10, 0, 1, 8'h00, 0, 8'h95, 0, 0};
    tv[10] = '{0, 2'b01, 0, 1, 8'h00, 0, 8'h4A, 0, 0};
    tv[11] = '{0, 2'b10, 1, 1, 8'h00, 0, 8'h95, 0, 0};

    for (int i = 0; i < 12; i++) begin
      step(tv[i].rst, tv[i].mode, tv[i].sir, tv[i].sil, tv[i].d, tv[i].start, "table");
      check("table.q",    Q,        tv[i].exp_q);
      check("table.busy", W'(Busy), W'(tv[i].exp_busy));
      check("table.done", W'(Done), W'(tv[i].exp_done));
    end

    run_xfer(0, "xfer");
    run_xfer(1, "xfer_noisy");

    // Reset lands on the 3rd shift edge of a transfer
    step(0, 2'b11, 0, 0, 8'hA5, 0, "rst_mid.load");
    step(0, 2'b00, 0, 0, 8'h00, 1, "rst_mid.accept");
    step(0, 2'b00, 1, 0, 8'h00, 0, "rst_mid.shift1");
    step(0, 2'b00, 1, 0, 8'h00, 0, "rst_mid.shift2");
    step(1, 2'b11, 1, 0, 8'hFF, 1, "rst_mid.reset");
    check("rst_mid.q",    Q,        8'h00);
    check("rst_mid.busy", W'(Busy), 8'h00);
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 2'b00, 1, 0, 8'h00, 0, "rst_mid.idle");
      if (Done) done_seen++;
    end
    check("rst_mid.done_never", W'(done_seen), 8'h00);
    step(0, 2'b00, 0, 0, 8'h00, 1, "rst_mid.restart");
    check("rst_mid.restart_busy", W'(Busy), 8'h01);
    for (int i = 0; i < W; i++) step(0, 2'b00, 0, 0, 8'h00, 0, "rst_mid.reshift");
    check("rst_mid.restart_done", W'(Done), 8'h01);

    // Randomised traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), 2'($urandom), 1'($urandom), 1'($urandom),
           8'($urandom), ($urandom_range(0, 7) == 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
